// File: rtl/bias_add_pipe_n.sv
// N-lane signed bias adder with a loadable bias bank; define BIAS_ADD_SAT_EN to clamp sums and flag sat_o.
// Latency 1 cycle: a beat accepted at edge k is presented on data_o after edge k.
// Backpressure: 2-entry output buffer keeps full rate; data_ready_o drops only while both entries are held.
module bias_add_pipe_n #(
    parameter int N        = 8,
    parameter int width_p  = 32,
    parameter int bias_w_p = 32,
    parameter int out_w_p  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N*bias_w_p-1:0]   bias_i,
    input  logic                    bias_load_i,
    input  logic                    data_valid_i,
    output logic                    data_ready_o,
    input  logic [N*width_p-1:0]    data_i,
    output logic                    data_valid_o,
    input  logic                    data_ready_i,
    output logic [N*out_w_p-1:0]    data_o,
    output logic [N-1:0]            sat_o
);

    localparam int IN_W   = (width_p > bias_w_p) ? width_p : bias_w_p;
    localparam int SUM_W  = IN_W + 1;
    localparam int EXT_W  = (SUM_W > out_w_p) ? SUM_W : out_w_p;
    localparam int BEAT_W = N * out_w_p;

    logic [N*bias_w_p-1:0] bias_q, bias_d;
    logic [BEAT_W-1:0]     sum_all;
    logic [N-1:0]          sat_all;

    // Buffer state: two slots, one-bit pointers, occupancy 0..2
    logic [BEAT_W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic [BEAT_W-1:0] out_q, out_d;
    logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              vld_q, vld_d, rdy_q, rdy_d;
    logic              push, pop;

    genvar g;
    for (g = 0; g < N; g++) begin : g_lane
        logic signed [EXT_W-1:0] d_ext;
        logic signed [EXT_W-1:0] b_ext;

        assign d_ext = EXT_W'($signed(data_i[g*width_p +: width_p]));
        assign b_ext = EXT_W'($signed(bias_q[g*bias_w_p +: bias_w_p]));
`ifdef BIAS_ADD_SAT_EN
        localparam logic [out_w_p-1:0] OUT_MAX = {1'b0, {(out_w_p-1){1'b1}}};
        localparam logic [out_w_p-1:0] OUT_MIN = {1'b1, {(out_w_p-1){1'b0}}};
        logic signed [EXT_W-1:0]   sum_w;
        logic [EXT_W-out_w_p:0]    hi;
        logic                      ovf;

        assign sum_w = d_ext + b_ext;
        // Representable iff every bit from the output sign bit upward agrees
        assign hi    = sum_w[EXT_W-1:out_w_p-1];
        assign ovf   = ~((&hi) | ~(|hi));
        assign sum_all[g*out_w_p +: out_w_p] = ovf ? (sum_w[EXT_W-1] ? OUT_MIN : OUT_MAX)
                                                   : sum_w[out_w_p-1:0];
        assign sat_all[g] = ovf;
`else
        assign sum_all[g*out_w_p +: out_w_p] = out_w_p'(d_ext + b_ext);
        assign sat_all[g] = 1'b0;
`endif
    end

    assign push = data_valid_i & rdy_q;
    assign pop  = vld_q & data_ready_i;

    always_comb begin
        bias_d   = bias_load_i ? bias_i : bias_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + 2'd1;
        else if (pop && !push)
            count_d = count_q - 2'd1;
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        if (push && !wr_ptr_q)
            mem0_d = sum_all;
        if (push && wr_ptr_q)
            mem1_d = sum_all;
        // Present the next head; when the buffer drains, keep the last popped beat
        out_d = out_q;
        if (count_d != 2'd0)
            out_d = rd_ptr_d ? mem1_d : mem0_d;
        vld_d = (count_d != 2'd0);
        rdy_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bias_q   <= '0;
            mem0_q   <= '0;
            mem1_q   <= '0;
            out_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            vld_q    <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            bias_q   <= bias_d;
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            out_q    <= out_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            rdy_q    <= rdy_d;
        end
    end

`ifdef BIAS_ADD_SAT_EN
    // Saturation flags ride in a parallel buffer indexed by the same pointers
    logic [N-1:0] sat0_q, sat0_d, sat1_q, sat1_d, sat_q, sat_d;

    always_comb begin
        sat0_d = sat0_q;
        sat1_d = sat1_q;
        if (push && !wr_ptr_q)
            sat0_d = sat_all;
        if (push && wr_ptr_q)
            sat1_d = sat_all;
        sat_d = sat_q;
        if (count_d != 2'd0)
            sat_d = rd_ptr_d ? sat1_d : sat0_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat0_q <= '0;
            sat1_q <= '0;
            sat_q  <= '0;
        end else begin
            sat0_q <= sat0_d;
            sat1_q <= sat1_d;
            sat_q  <= sat_d;
        end
    end

    assign sat_o = sat_q;
`else
    assign sat_o = '0;
`endif

    assign data_o       = out_q;
    assign data_valid_o = vld_q;
    assign data_ready_o = rdy_q;

endmodule

// File: tb/tb_bias_add_pipe_n.sv
// Directed bench for bias_add_pipe_n at default parameters (8 lanes, 32-bit data/bias/out).
module tb_bias_add_pipe_n;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] bias_i;
    logic         bias_load;
    logic         dvi;
    logic         dro;
    logic [255:0] data_i;
    logic         dvo;
    logic         dri;
    logic [255:0] data_o;
    logic [7:0]   sat_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bias_add_pipe_n dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bias_i       (bias_i),
        .bias_load_i  (bias_load),
        .data_valid_i (dvi),
        .data_ready_o (dro),
        .data_i       (data_i),
        .data_valid_o (dvo),
        .data_ready_i (dri),
        .data_o       (data_o),
        .sat_o        (sat_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rep(input logic [31:0] v);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [255:0] ramp(input logic [31:0] base);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = base + 32'(i);
        return r;
    endfunction

    // Reference lane: 33-bit signed sum, then clamp or wrap to 32 bits; bit 32 is the flag
    function automatic logic [32:0] mlane(input logic [31:0] d, input logic [31:0] b);
        logic [32:0] s;
        s = {d[31], d} + {b[31], b};
`ifdef BIAS_ADD_SAT_EN
        if (s[32] != s[31])
            return {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
`endif
        return {1'b0, s[31:0]};
    endfunction

    logic [255:0] rb, rd, ed;
    logic [7:0]   es;
    logic [32:0]  ml;

    initial begin
        rst = 1'b1; bias_i = '0; bias_load = 1'b0; dvi = 1'b0; data_i = '0; dri = 1'b1;
        tick(); tick();
        chk("rst_valid", dvo, 0);
        chk("rst_ready", dro, 1);
        chk("rst_data", data_o, 0);
        chk("rst_sat", sat_o, 0);
        rst = 1'b0;
        tick();

        // Bias load, then ramp data
        bias_i = rep(3); bias_load = 1'b1;
        tick();
        bias_load = 1'b0; data_i = ramp(0); dvi = 1'b1;
        tick();
        dvi = 1'b0;
        chk("load_valid", dvo, 1);
        chk("load_data", data_o, ramp(3));
        tick();
        chk("load_drain", dvo, 0);

        // Load coinciding with a beat uses the old bias
        bias_i = rep(1); bias_load = 1'b1;
        tick();
        bias_i = rep(10); data_i = '0; dvi = 1'b1;
        tick();
        bias_load = 1'b0;
        chk("same_cyc_old_bias", data_o, rep(1));
        tick();
        dvi = 1'b0;
        chk("next_new_bias", data_o, rep(10));
        chk("next_valid", dvo, 1);
        tick();
        chk("same_cyc_drain", dvo, 0);

        // Backpressure with bias 10: A=100, B=200, C=300
        dri = 1'b0; data_i = rep(100); dvi = 1'b1;
        tick();
        chk("bp_a_ready", dro, 1);
        chk("bp_a_data", data_o, rep(110));
        data_i = rep(200);
        tick();
        chk("bp_full_ready", dro, 0);
        chk("bp_full_valid", dvo, 1);
        data_i = rep(300);
        tick();
        chk("bp_hold_ready", dro, 0);
        chk("bp_hold_data", data_o, rep(110));
        dri = 1'b1;
        tick();
        chk("bp_pop_a_ready", dro, 1);
        chk("bp_b_data", data_o, rep(210));
        tick();
        dvi = 1'b0;
        chk("bp_c_data", data_o, rep(310));
        chk("bp_c_valid", dvo, 1);
        tick();
        chk("bp_drain", dvo, 0);

        // Streaming: random bias, 100 random beats with downstream always ready
        for (int i = 0; i < 8; i++) rb[i*32 +: 32] = $urandom;
        bias_i = rb; bias_load = 1'b1;
        tick();
        bias_load = 1'b0;
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < 8; i++) begin
                rd[i*32 +: 32] = $urandom;
                ml = mlane(rd[i*32 +: 32], rb[i*32 +: 32]);
                ed[i*32 +: 32] = ml[31:0];
                es[i] = ml[32];
            end
            data_i = rd; dvi = 1'b1;
            tick();
            chk("stream_valid", dvo, 1);
            chk("stream_ready", dro, 1);
            chk("stream_data", data_o, ed);
            chk("stream_sat", sat_o, es);
        end
        dvi = 1'b0;
        tick();
        chk("stream_drain", dvo, 0);

        // Positive overflow
        bias_i = rep(1); bias_load = 1'b1;
        tick();
        bias_load = 1'b0; data_i = rep(32'h7FFF_FFFF); dvi = 1'b1;
        tick();
        dvi = 1'b0;
`ifdef BIAS_ADD_SAT_EN
        chk("ovf_pos_data", data_o, rep(32'h7FFF_FFFF));
        chk("ovf_pos_sat", sat_o, 8'hFF);
`else
        chk("ovf_pos_data", data_o, rep(32'h8000_0000));
        chk("ovf_pos_sat", sat_o, 8'h00);
`endif
        tick();

        // Negative overflow
        bias_i = rep(32'hFFFF_FFFF); bias_load = 1'b1;
        tick();
        bias_load = 1'b0; data_i = rep(32'h8000_0000); dvi = 1'b1;
        tick();
        dvi = 1'b0;
`ifdef BIAS_ADD_SAT_EN
        chk("ovf_neg_data", data_o, rep(32'h8000_0000));
        chk("ovf_neg_sat", sat_o, 8'hFF);
`else
        chk("ovf_neg_data", data_o, rep(32'h7FFF_FFFF));
        chk("ovf_neg_sat", sat_o, 8'h00);
`endif
        tick();

        // Reset mid-stream with two beats buffered (bias currently -1)
        bias_i = rep(7); bias_load = 1'b1;
        tick();
        bias_load = 1'b0; dri = 1'b0; data_i = rep(1); dvi = 1'b1;
        tick();
        data_i = rep(2);
        tick();
        dvi = 1'b0;
        chk("pre_rst_full", dro, 0);
        chk("pre_rst_data", data_o, rep(8));
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", dvo, 0);
        chk("mid_rst_ready", dro, 1);
        chk("mid_rst_data", data_o, 0);
        tick();
        rst = 1'b0;
        tick();
        dri = 1'b1; data_i = rep(5); dvi = 1'b1;
        tick();
        dvi = 1'b0;
        chk("post_rst_bias0", data_o, rep(5));
        chk("post_rst_valid", dvo, 1);
        tick();
        chk("post_rst_drain", dvo, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
